// File: rtl/wr_addr_gen_pkg.sv
// Shared LSTM buffer constants: default widths, matrix geometry and the
// write-generator state encoding.
package wr_addr_gen_pkg;
   localparam int LSTM_ADDR_WIDTH = 12;
   localparam int LSTM_DATA_WIDTH = 16;
   localparam int LSTM_NUM_COLS   = 53;
   localparam int LSTM_NUM_ROWS   = 4;
   localparam int LSTM_ROW_STRIDE = 64;
   localparam int LSTM_BASE       = 0;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;
endpackage

// File: rtl/wr_addr_gen_if.sv
// Result stream in, RAM write port out; slave side is the address generator.
interface wr_addr_gen_if
   import wr_addr_gen_pkg::*;
#(
   parameter int ADDR_WIDTH = LSTM_ADDR_WIDTH,
   parameter int DATA_WIDTH = LSTM_DATA_WIDTH
);
   logic                  en;
   logic                  i_clr;
   logic                  i_valid;
   logic [DATA_WIDTH-1:0] i_data;
   logic [ADDR_WIDTH-1:0] o_addr;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_we;
   logic                  o_busy;
   logic                  o_done;

   modport master (output en, i_clr, i_valid, i_data,
                   input  o_addr, o_data, o_we, o_busy, o_done);
   modport slave  (input  en, i_clr, i_valid, i_data,
                   output o_addr, o_data, o_we, o_busy, o_done);
endinterface

// File: rtl/wr_addr_gen_rc_counter.sv
// Row/column walker over a strided row-major matrix; row start address is
// accumulated rather than multiplied.
module rc_counter #(
   parameter int ADDR_WIDTH = 12,
   parameter int NUM_COLS   = 53,
   parameter int NUM_ROWS   = 4,
   parameter int ROW_STRIDE = 64,
   parameter int BASE       = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  step_i,
   output logic [ADDR_WIDTH-1:0] ptr_o,
   output logic                  wrap_o
);
   localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic                  col_last, row_last;

   assign col_last = (col_q == CW'(NUM_COLS - 1));
   assign row_last = (row_q == RW'(NUM_ROWS - 1));
   assign wrap_o   = col_last && row_last;
   assign ptr_o    = base_q + ADDR_WIDTH'(col_q);

   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      base_d = base_q;
      if (clr_i || (step_i && wrap_o)) begin
         col_d  = '0;
         row_d  = '0;
         base_d = ADDR_WIDTH'(BASE);
      end else if (step_i) begin
         if (!col_last) begin
            col_d = col_q + 1'b1;
         end else begin
            col_d  = '0;
            row_d  = row_q + 1'b1;
            base_d = base_q + ADDR_WIDTH'(ROW_STRIDE);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q  <= '0;
         row_q  <= '0;
         base_q <= ADDR_WIDTH'(BASE);
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         base_q <= base_d;
      end
   end
endmodule

// File: rtl/wr_addr_gen.sv
// Write-side address generator: registers each accepted result into a
// row-major RAM and flags the last write of every matrix.
module wr_addr_gen
   import wr_addr_gen_pkg::*;
#(
   parameter int ADDR_WIDTH = LSTM_ADDR_WIDTH,
   parameter int DATA_WIDTH = LSTM_DATA_WIDTH,
   parameter int NUM_COLS   = LSTM_NUM_COLS,
   parameter int NUM_ROWS   = LSTM_NUM_ROWS,
   parameter int ROW_STRIDE = LSTM_ROW_STRIDE,
   parameter int BASE       = LSTM_BASE
) (
   input  logic          clk,
   input  logic          rst,
   wr_addr_gen_if.slave  bus
);
   state_t                state_q, state_d;
   logic                  accept, clr, last;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  we_q, done_q;

   assign clr    = bus.en && bus.i_clr;
   assign accept = bus.en && !bus.i_clr && bus.i_valid;

   rc_counter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_COLS   (NUM_COLS),
      .NUM_ROWS   (NUM_ROWS),
      .ROW_STRIDE (ROW_STRIDE),
      .BASE       (BASE)
   ) u_rc (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (clr),
      .step_i (accept),
      .ptr_o  (ptr),
      .wrap_o (last)
   );

   // With a 1x1 matrix every accept is the last one, so FILL is never entered.
   always_comb begin
      state_d = state_q;
      if (clr)         state_d = IDLE;
      else if (accept) state_d = last ? IDLE : FILL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= accept;
         done_q  <= accept && last;
         if (accept) begin
            addr_q <= ptr;
            data_q <= bus.i_data;
         end
      end
   end

   assign bus.o_addr = addr_q;
   assign bus.o_data = data_q;
   assign bus.o_we   = we_q;
   assign bus.o_done = done_q;
   assign bus.o_busy = (state_q == FILL);
endmodule

// File: tb/tb_wr_addr_gen.sv
// Directed bench for wr_addr_gen at default geometry (53 cols, 4 rows, stride 64).
module tb_wr_addr_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   wr_addr_gen_if bus ();

   wr_addr_gen u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      bus.i_clr = 1'b1; bus.i_valid = 1'b0; bus.en = 1'b1;
      step();
      bus.i_clr = 1'b0;
   endtask

   task automatic test_reset();
      bus.en = 1'b1; bus.i_clr = 1'b0; bus.i_valid = 1'b0; bus.i_data = '0;
      rst = 1'b1;
      step(); step();
      checks++; if (bus.o_addr !== 12'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", bus.o_addr); end
      checks++; if (bus.o_data !== 16'd0) begin errors++; $display("FAIL reset_data got %0h exp 0", bus.o_data); end
      checks++; if (bus.o_we   !== 1'b0)  begin errors++; $display("FAIL reset_we got %b exp 0", bus.o_we); end
      checks++; if (bus.o_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", bus.o_busy); end
      checks++; if (bus.o_done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b exp 0", bus.o_done); end
      #3 rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      logic [15:0] dv [3];
      dv[0] = 16'h00A1; dv[1] = 16'h00A2; dv[2] = 16'h00A3;
      for (int k = 0; k < 3; k++) begin
         bus.i_valid = 1'b1; bus.i_data = dv[k];
         step();
         checks++; if (bus.o_we !== 1'b1) begin errors++; $display("FAIL basic_we k=%0d got %b exp 1", k, bus.o_we); end
         checks++; if (bus.o_addr !== 12'(k)) begin errors++; $display("FAIL basic_addr k=%0d got %0d exp %0d", k, bus.o_addr, k); end
         checks++; if (bus.o_data !== dv[k]) begin errors++; $display("FAIL basic_data k=%0d got %0h exp %0h", k, bus.o_data, dv[k]); end
      end
      bus.i_valid = 1'b0;
      step();
      checks++; if (bus.o_we !== 1'b0) begin errors++; $display("FAIL basic_we_off got %b exp 0", bus.o_we); end
      checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", bus.o_busy); end
      do_clear();
   endtask

   task automatic test_row_wrap();
      for (int k = 0; k < 54; k++) begin
         bus.i_valid = 1'b1; bus.i_data = 16'(k);
         step();
         checks++; if (bus.o_we !== 1'b1) begin errors++; $display("FAIL wrap_we k=%0d got %b exp 1", k, bus.o_we); end
         if (k == 52) begin
            checks++; if (bus.o_addr !== 12'd52) begin errors++; $display("FAIL wrap_addr53 got %0d exp 52", bus.o_addr); end
         end
         if (k == 53) begin
            checks++; if (bus.o_addr !== 12'd64) begin errors++; $display("FAIL wrap_addr54 got %0d exp 64", bus.o_addr); end
         end
      end
      bus.i_valid = 1'b0;
      do_clear();
   endtask

   task automatic test_full_matrix();
      int m, ea;
      for (int k = 0; k < 213; k++) begin
         bus.i_valid = 1'b1; bus.i_data = 16'(k + 16'h100);
         step();
         m  = k % 212;
         ea = (m / 53) * 64 + (m % 53);
         checks++; if (bus.o_we !== 1'b1) begin errors++; $display("FAIL full_we k=%0d got %b exp 1", k, bus.o_we); end
         checks++; if (bus.o_addr !== 12'(ea)) begin errors++; $display("FAIL full_addr k=%0d got %0d exp %0d", k, bus.o_addr, ea); end
         checks++; if (bus.o_done !== (k == 211)) begin errors++; $display("FAIL full_done k=%0d got %b exp %b", k, bus.o_done, k == 211); end
         checks++; if (bus.o_busy !== (k != 211)) begin errors++; $display("FAIL full_busy k=%0d got %b exp %b", k, bus.o_busy, k != 211); end
      end
      bus.i_valid = 1'b0;
      step();
      checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL full_done_after got %b exp 0", bus.o_done); end
      do_clear();
   endtask

   task automatic test_enable_low();
      for (int k = 0; k < 10; k++) begin
         bus.i_valid = 1'b1; bus.i_data = 16'h0200 + 16'(k);
         step();
      end
      bus.en = 1'b0; bus.i_data = 16'hDEAD;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++; if (bus.o_we !== 1'b0) begin errors++; $display("FAIL en_we k=%0d got %b exp 0", k, bus.o_we); end
         checks++; if (bus.o_addr !== 12'd9) begin errors++; $display("FAIL en_addr_hold k=%0d got %0d exp 9", k, bus.o_addr); end
         checks++; if (bus.o_data !== 16'h0209) begin errors++; $display("FAIL en_data_hold k=%0d got %0h exp 209", k, bus.o_data); end
      end
      bus.en = 1'b1; bus.i_data = 16'h020A;
      step();
      checks++; if (bus.o_we !== 1'b1) begin errors++; $display("FAIL en_resume_we got %b exp 1", bus.o_we); end
      checks++; if (bus.o_addr !== 12'd10) begin errors++; $display("FAIL en_resume_addr got %0d exp 10", bus.o_addr); end
      bus.i_valid = 1'b0;
      do_clear();
   endtask

   task automatic test_clr_valid();
      // 59 accepts leave the pointer at row 1, col 6 = 64 + 6 = 70
      for (int k = 0; k < 59; k++) begin
         bus.i_valid = 1'b1; bus.i_data = 16'(k);
         step();
      end
      bus.i_clr = 1'b1; bus.i_data = 16'hBEEF;
      step();
      checks++; if (bus.o_we !== 1'b0) begin errors++; $display("FAIL clr_we got %b exp 0", bus.o_we); end
      checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b exp 0", bus.o_busy); end
      bus.i_clr = 1'b0; bus.i_data = 16'h0C0C;
      step();
      checks++; if (bus.o_we !== 1'b1) begin errors++; $display("FAIL clr_next_we got %b exp 1", bus.o_we); end
      checks++; if (bus.o_addr !== 12'd0) begin errors++; $display("FAIL clr_next_addr got %0d exp 0", bus.o_addr); end
      bus.i_valid = 1'b0;
      do_clear();
   endtask

   task automatic test_async_reset();
      // 90 accepts: the 90th lands at row 1, col 36 = 100
      for (int k = 0; k < 90; k++) begin
         bus.i_valid = 1'b1; bus.i_data = 16'(k);
         step();
      end
      checks++; if (bus.o_addr !== 12'd100) begin errors++; $display("FAIL arst_pre_addr got %0d exp 100", bus.o_addr); end
      checks++; if (bus.o_we !== 1'b1) begin errors++; $display("FAIL arst_pre_we got %b exp 1", bus.o_we); end
      bus.i_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.o_we !== 1'b0) begin errors++; $display("FAIL arst_we got %b exp 0", bus.o_we); end
      checks++; if (bus.o_addr !== 12'd0) begin errors++; $display("FAIL arst_addr got %0d exp 0", bus.o_addr); end
      checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b exp 0", bus.o_busy); end
      step();
      #3 rst = 1'b0;
      step();
      bus.i_valid = 1'b1; bus.i_data = 16'h0777;
      step();
      checks++; if (bus.o_we !== 1'b1) begin errors++; $display("FAIL arst_after_we got %b exp 1", bus.o_we); end
      checks++; if (bus.o_addr !== 12'd0) begin errors++; $display("FAIL arst_after_addr got %0d exp 0", bus.o_addr); end
      checks++; if (bus.o_data !== 16'h0777) begin errors++; $display("FAIL arst_after_data got %0h exp 777", bus.o_data); end
      bus.i_valid = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_row_wrap();
      test_full_matrix();
      test_enable_low();
      test_clr_valid();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/wr_addr_gen.md
# wr_addr_gen

Write-side address generator for the LSTM backprop result buffers. It accepts a stream of datapath results with a valid strobe and registers them into a row-major on-chip RAM: it produces the write address, write enable and data, plus a done pulse at the end of each matrix. It is the counterpart of the prescaled read-address generators that feed weights into the datapath.

## Interface
Parameters:
- ADDR_WIDTH, 12, width of RAM address.
- DATA_WIDTH, 16, width of result word.
- NUM_COLS, 53, elements per row.
- NUM_ROWS, 4, rows per matrix.
- ROW_STRIDE, 64, address distance between row starts; must be ≥ NUM_COLS.
- BASE, 0, address of element (0,0).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  block enable; when low, i_valid and i_clr are ignored and all state holds.
- i_clr  in  1  synchronous restart of the matrix pointer.
- i_valid  in  1  one result available this cycle.
- i_data  in  DATA_WIDTH  result word.
- o_addr  out  ADDR_WIDTH  RAM write address.
- o_data  out  DATA_WIDTH  RAM write data.
- o_we  out  1  RAM write enable, one cycle per accepted result.
- o_busy  out  1  a matrix is partially written.
- o_done  out  1  one-cycle pulse coincident with the last write of a matrix.

## Operation
- Internal state:
  - col counter: 0..NUM_COLS-1.
  - row counter: 0..NUM_ROWS-1.
  - row_base register: BASE + row·ROW_STRIDE, kept by accumulation with no multiplier.
  - FSM with states IDLE and FILL.
- Write pointer is row_base + col, truncated to ADDR_WIDTH (modulo 2^ADDR_WIDTH).
- Accept: en=1, i_clr=0, i_valid=1. On accept:
  - o_we, o_addr and o_data load in the following cycle.
  - If col < NUM_COLS-1: col increments.
  - Otherwise: col←0, row increments and row_base += ROW_STRIDE.
  - On the last element (row=NUM_ROWS-1, col=NUM_COLS-1): col←0, row←0, row_base←BASE, and o_done is registered high alongside that write.
- FSM transitions:
  - IDLE→FILL on any accept that is not the last element.
  - FILL→IDLE on the last-element accept.
  - Degenerate case NUM_COLS=NUM_ROWS=1: stays in IDLE and pulses o_done on every write.
- o_busy = (state==FILL), registered.
- i_clr with en=1:
  - col←0, row←0, row_base←BASE, state←IDLE.
  - o_we←0 and o_done←0.
  - Wins over a simultaneous i_valid; that result is dropped.
- en=0: o_we and o_done go 0 next cycle. Counters, state, o_addr and o_data hold.
- No backpressure. The RAM is assumed to accept one write per cycle.

## Timing
- Reset values: o_addr=0, o_data=0, o_we=0, o_busy=0, o_done=0. Internally col=0, row=0, row_base=BASE, state=IDLE.
- Latency is one cycle from accepted i_valid to o_we.
- Back-to-back i_valid every cycle gives a contiguous o_we stream at full rate, including across row and matrix wrap, with no bubble.
- o_done is high for exactly one cycle, in the same cycle as the final o_we.
- o_busy drops in the cycle after the final write is accepted, i.e. together with o_done.
- rst asserted mid-stream clears all outputs immediately (asynchronously). Any pending write is lost.

## Structure
- Shared LSTM package: default ADDR_WIDTH/DATA_WIDTH, matrix geometry constants (NUM_COLS=53 etc.) and the 1-bit state encoding constants IDLE=0 and FILL=1.
- One natural sub-module: `rc_counter`, a row/column counter with wrap flag and row_base accumulator. It is reusable by the read-side generators.
- Output register stage lives in the top level.

## Test plan
All scenarios use default parameters.
- **Basic write:** reset, then i_valid on 3 consecutive cycles with i_data 0xA1, 0xA2, 0xA3 → o_we high for 3 cycles starting one cycle later, o_addr 0, 1, 2, o_data 0xA1..0xA3, o_busy=1 afterwards.
- **Row wrap:** 54 consecutive valids → write 53 at o_addr 52, write 54 at o_addr 64, no gap in o_we.
- **Full matrix:** 212 consecutive valids → last write at o_addr 244 (3·64+52) with o_done=1 in that cycle only. o_busy=0 from that cycle on. Valid 213 writes at o_addr 0.
- **Enable low:** en=0 with i_valid=1 for 5 cycles mid-row at pointer 10 → no o_we, o_addr holds. After en=1, next write at o_addr 10.
- **Clear vs. valid:** pointer at 70, i_clr and i_valid together → no write, o_busy=0. Next valid writes o_addr 0.
- **Async reset:** rst asserted asynchronously while o_we=1 at o_addr 100 → o_we, o_addr and o_busy go 0 without waiting for a clock edge. After release, the first write is at o_addr 0.
